sha2_msg_schedule: RTL and testbench

SHA2_MSG_SCHEDULE -- requirements
Module: sha2_msg_schedule

---
 rtl/sha2_msg_schedule.sv | 188 ++++++++++++++++++
 tb/tb_sha2_msg_schedule.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : sha2_msg_schedule
//  Purpose  : SHA-2 message schedule generator. Accepts the 16 words of one
//             message block, then streams the ROUNDS schedule words W[0..R-1]
//             to a consumer through a valid/ready handshake. The schedule is
//             produced with a sliding 16-word window: win[0] is always the
//             word on offer, and each accepted word shifts the window and
//             appends the next expanded word at win[15].
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WORD_W   word width, 32 (SHA-224/256) or 64 (SHA-384/512)
//    ROUNDS   schedule words emitted per block, 16..80
//    BSWAP    1 = byte-reverse every accepted input word
//  Ports
//    clk        in   1       clock, all state changes on the rising edge
//    rst        in   1       synchronous active-high reset
//    clear      in   1       synchronous abort, same effect as rst
//    in_valid   in   1       message word offered
//    in_ready   out  1       block accepts a message word (IDLE/LOAD)
//    in_data    in   WORD_W  message word, word 0 of the block first
//    w_valid    out  1       schedule word W[t] presented (EXPAND)
//    w_ready    in   1       consumer accepts W[t]
//    w_data     out  WORD_W  schedule word W[t]
//    w_index    out  7       round index t
//    w_last     out  1       high with W[ROUNDS-1]
// ============================================================================
module sha2_msg_schedule #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int BSWAP  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [6:0]        w_index,
    output logic              w_last
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_LOAD   = 2'd1;
    localparam logic [1:0] C_ST_EXPAND = 2'd2;
    localparam logic [6:0] C_LAST_T    = 7'(ROUNDS - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        load_cnt_q, load_cnt_d;
    logic [6:0]        t_q, t_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];

    logic [WORD_W-1:0] w_in_word;
    logic [WORD_W-1:0] w_sig0;
    logic [WORD_W-1:0] w_sig1;
    logic [WORD_W-1:0] w_new;

    // ------------------------------------------------------------------------
    // Input word ordering: optional byte reversal for little-endian sources.
    // ------------------------------------------------------------------------
    generate
        if (BSWAP == 1) begin : g_bswap
            for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
                assign w_in_word[8*b +: 8] = in_data[WORD_W-8-8*b +: 8];
            end
        end else begin : g_no_bswap
            assign w_in_word = in_data;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Small sigma functions. Rotations are written as concatenations so the
    // wiring is explicit; the shifts fill with zeros.
    //   sigma0 operates on win[1] (W[t+1]), sigma1 on win[14] (W[t+14]).
    // ------------------------------------------------------------------------
    generate
        if (WORD_W == 64) begin : g_sigma64
            assign w_sig0 = {win_q[1][0],    win_q[1][WORD_W-1:1]}
                          ^ {win_q[1][7:0],  win_q[1][WORD_W-1:8]}
                          ^ (win_q[1] >> 7);
            assign w_sig1 = {win_q[14][18:0], win_q[14][WORD_W-1:19]}
                          ^ {win_q[14][60:0], win_q[14][WORD_W-1:61]}
                          ^ (win_q[14] >> 6);
        end else begin : g_sigma32
            assign w_sig0 = {win_q[1][6:0],  win_q[1][WORD_W-1:7]}
                          ^ {win_q[1][17:0], win_q[1][WORD_W-1:18]}
                          ^ (win_q[1] >> 3);
            assign w_sig1 = {win_q[14][16:0], win_q[14][WORD_W-1:17]}
                          ^ {win_q[14][18:0], win_q[14][WORD_W-1:19]}
                          ^ (win_q[14] >> 10);
        end
    endgenerate

    // W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t], mod 2^WORD_W
    assign w_new = w_sig1 + win_q[9] + w_sig0 + win_q[0];

    // ------------------------------------------------------------------------
    // State register (rst and clear both return to an empty IDLE block and
    // win over any handshake in the same cycle).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q    <= C_ST_IDLE;
            load_cnt_q <= 4'd0;
            t_q        <= 7'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        case (state_q)
            C_ST_IDLE: begin
                if (in_valid) begin
                    win_d[0]   = w_in_word;
                    load_cnt_d = 4'd1;
                    state_d    = C_ST_LOAD;
                end
            end
            C_ST_LOAD: begin
                if (in_valid) begin
                    win_d[load_cnt_q] = w_in_word;
                    // The 4-bit counter wraps to 0 on the 16th word.
                    load_cnt_d        = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d = C_ST_EXPAND;
                        t_d     = 7'd0;
                    end
                end
            end
            C_ST_EXPAND: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = w_new;
                    if (t_q == C_LAST_T) begin
                        // Block complete: round index parks at 0 in IDLE.
                        state_d = C_ST_IDLE;
                        t_d     = 7'd0;
                    end else begin
                        t_d = t_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q != C_ST_EXPAND);
        w_valid  = (state_q == C_ST_EXPAND);
        w_last   = (state_q == C_ST_EXPAND) && (t_q == C_LAST_T);
        w_data   = win_q[0];
        w_index  = t_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sha2_msg_schedule.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sha2_msg_schedule
//  Purpose  : Self-checking bench for sha2_msg_schedule. Three instances:
//             A = SHA-256 schedule (32/64, no swap), B = SHA-512 schedule
//             (64/80), C = SHA-256 schedule with byte-swapped input.
//             Expected words come from a textbook recurrence model over a
//             whole block array, plus a table of known "abc" words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha2_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst;

    // Instance A
    logic        a_clear, a_in_valid, a_in_ready, a_w_valid, a_w_ready, a_w_last;
    logic [31:0] a_in_data, a_w_data;
    logic [6:0]  a_w_index;
    // Instance B
    logic        b_clear, b_in_valid, b_in_ready, b_w_valid, b_w_ready, b_w_last;
    logic [63:0] b_in_data, b_w_data;
    logic [6:0]  b_w_index;
    // Instance C
    logic        c_clear, c_in_valid, c_in_ready, c_w_valid, c_w_ready, c_w_last;
    logic [31:0] c_in_data, c_w_data;
    logic [6:0]  c_w_index;

    sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64), .BSWAP(0)) u_dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .w_valid(a_w_valid), .w_ready(a_w_ready), .w_data(a_w_data),
        .w_index(a_w_index), .w_last(a_w_last)
    );
    sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80), .BSWAP(0)) u_dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .w_valid(b_w_valid), .w_ready(b_w_ready), .w_data(b_w_data),
        .w_index(b_w_index), .w_last(b_w_last)
    );
    sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64), .BSWAP(1)) u_dut_c (
        .clk(clk), .rst(rst), .clear(c_clear),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .w_valid(c_w_valid), .w_ready(c_w_ready), .w_data(c_w_data),
        .w_index(c_w_index), .w_last(c_w_last)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic model32(input logic [31:0] m [16], output logic [63:0] w [80]);
        logic [31:0] v [64];
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) v[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            s0   = rr32(v[t-15], 7) ^ rr32(v[t-15], 18) ^ (v[t-15] >> 3);
            s1   = rr32(v[t-2], 17) ^ rr32(v[t-2], 19) ^ (v[t-2] >> 10);
            v[t] = s1 + v[t-7] + s0 + v[t-16];
        end
        for (int t = 0; t < 80; t++) w[t] = (t < 64) ? 64'(v[t]) : 64'd0;
    endtask

    task automatic model64(input logic [63:0] m [16], output logic [63:0] w [80]);
        logic [63:0] s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 80; t++) begin
            s0   = rr64(w[t-15], 1) ^ rr64(w[t-15], 8) ^ (w[t-15] >> 7);
            s1   = rr64(w[t-2], 19) ^ rr64(w[t-2], 61) ^ (w[t-2] >> 6);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
    endtask

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // ---------------- output monitors ----------------
    typedef struct {
        logic [63:0] data;
        int          idx;
        bit          last;
        int          cyc;
    } obs_t;

    obs_t a_q[$];
    obs_t b_q[$];
    obs_t c_q[$];

    logic [31:0] a_hold_d;
    logic [6:0]  a_hold_i;
    bit          a_stalled = 1'b0;

    // A: record accepted words; while stalled, output must not move.
    always @(negedge clk) begin
        if (!rst && !a_clear && a_w_valid) begin
            if (a_stalled) begin
                chk("a_stall_data", 64'(a_w_data), 64'(a_hold_d));
                chk("a_stall_index", 64'(a_w_index), 64'(a_hold_i));
            end
            if (a_w_ready) begin
                a_q.push_back('{64'(a_w_data), int'(a_w_index), a_w_last, cyc});
                a_stalled <= 1'b0;
            end else begin
                a_stalled <= 1'b1;
                a_hold_d  <= a_w_data;
                a_hold_i  <= a_w_index;
            end
        end else begin
            a_stalled <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && !b_clear && b_w_valid && b_w_ready)
            b_q.push_back('{b_w_data, int'(b_w_index), b_w_last, cyc});
        if (!rst && !c_clear && c_w_valid && c_w_ready)
            c_q.push_back('{64'(c_w_data), int'(c_w_index), c_w_last, cyc});
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return a_q.size();
            1:       return b_q.size();
            default: return c_q.size();
        endcase
    endfunction

    function automatic obs_t get_obs(input int which, input int i);
        case (which)
            0:       return a_q[i];
            1:       return b_q[i];
            default: return c_q[i];
        endcase
    endfunction

    // A's consumer: ready held high or toggled pseudo-randomly.
    bit a_rand_rdy = 1'b0;
    initial begin
        a_w_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            a_w_ready = a_rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offers words start..15 to A; called and returns at posedge+1.
    task automatic feed_a(input logic [31:0] m [16], input int start,
                          input bit gaps, input bit hold_valid);
        int k = start;
        int guard = 0;
        bit hs;
        while (k < 16) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                a_in_valid = 1'b0;
            end else begin
                a_in_valid = 1'b1;
                a_in_data  = m[k];
            end
            @(negedge clk);
            hs = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
            if (guard > 1000) begin
                fail_now("feed_a");
                break;
            end
        end
        if (!hold_valid) a_in_valid = 1'b0;
        if (k == 16) chk("a_first_w_valid", 64'(a_w_valid), 64'd1);
    endtask

    task automatic feed_b(input logic [63:0] m [16]);
        for (int k = 0; k < 16; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = m[k];
            @(negedge clk);
            chk("b_in_ready_load", 64'(b_in_ready), 64'd1);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        chk("b_first_w_valid", 64'(b_w_valid), 64'd1);
    endtask

    task automatic feed_c(input logic [31:0] m [16]);
        for (int k = 0; k < 16; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = m[k];
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
    endtask

    task automatic wait_n(input int which, input int n);
        int g = 0;
        while (qsize(which) < n && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (qsize(which) < n) fail_now("wait_words");
    endtask

    task automatic check_blk(input int which, input int base,
                             input logic [63:0] exp [80], input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            if (base + i >= qsize(which)) begin
                fail_now("check_blk_short");
                break;
            end
            o = get_obs(which, base + i);
            chk($sformatf("w_data[%0d]", i), o.data, exp[i]);
            chk($sformatf("w_index[%0d]", i), 64'(o.idx), 64'(i));
            chk($sformatf("w_last[%0d]", i), 64'(o.last), 64'(i == n - 1));
        end
    endtask

    task automatic check_idle_a(input string name);
        chk({name, "_in_ready"}, 64'(a_in_ready), 64'd1);
        chk({name, "_w_valid"}, 64'(a_w_valid), 64'd0);
        chk({name, "_w_data"}, 64'(a_w_data), 64'd0);
        chk({name, "_w_index"}, 64'(a_w_index), 64'd0);
        chk({name, "_w_last"}, 64'(a_w_last), 64'd0);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        int          which;
        int          idx;
        logic [63:0] w;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] abc32 [16];
        logic [63:0] abc64 [16];
        logic [31:0] m32 [16];
        logic [31:0] mb32 [16];
        logic [31:0] sw32 [16];
        logic [63:0] m64 [16];
        logic [63:0] exp_abc [80];
        logic [63:0] exp_a [80];
        logic [63:0] exp_b [80];
        logic [63:0] exp_64 [80];
        vec_t        tab [10];
        int          base, base1, base2, qa, g;
        bit          prev_last, acc;
        obs_t        o0, o1;

        rst = 1'b1;
        a_clear = 1'b0; b_clear = 1'b0; c_clear = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        b_w_ready = 1'b1; c_w_ready = 1'b1;

        for (int i = 0; i < 16; i++) begin
            abc32[i] = 32'd0;
            abc64[i] = 64'd0;
        end
        abc32[0]  = 32'h6162_6380;
        abc32[15] = 32'h0000_0018;
        abc64[0]  = 64'h6162_6380_0000_0000;
        abc64[15] = 64'h0000_0000_0000_0018;

        tab[0] = '{0, 0,  64'h6162_6380};
        tab[1] = '{0, 1,  64'h0};
        tab[2] = '{0, 15, 64'h18};
        tab[3] = '{0, 16, 64'h6162_6380};
        tab[4] = '{0, 17, 64'h000F_0000};
        tab[5] = '{1, 0,  64'h6162_6380_0000_0000};
        tab[6] = '{1, 15, 64'h18};
        tab[7] = '{1, 16, 64'h6162_6380_0000_0000};
        tab[8] = '{1, 17, 64'h0003_0000_0000_00C0};
        tab[9] = '{2, 0,  64'h6162_6380};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_idle_a("rst_a");
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        chk("rst_b_w_valid", 64'(b_w_valid), 64'd0);
        chk("rst_c_in_ready", 64'(c_in_ready), 64'd1);
        chk("rst_c_w_valid", 64'(c_w_valid), 64'd0);

        model32(abc32, exp_abc);

        // Test 1: abc block, ready high
        base = a_q.size();
        feed_a(abc32, 0, 1'b0, 1'b0);
        wait_n(0, base + 64);
        chk("t1_in_ready_after_last", 64'(a_in_ready), 64'd1);
        check_blk(0, base, exp_abc, 64);
        if (a_q.size() >= base + 64) begin
            o0 = a_q[base];
            o1 = a_q[base + 63];
            chk("t1_throughput", 64'(o1.cyc - o0.cyc), 64'd63);
        end
        base1 = base;

        // Test 2: same block, gapped input, random ready
        a_rand_rdy = 1'b1;
        base = a_q.size();
        feed_a(abc32, 0, 1'b1, 1'b0);
        wait_n(0, base + 64);
        check_blk(0, base, exp_abc, 64);

        // Random blocks under back-pressure
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) m32[i] = $urandom;
            model32(m32, exp_a);
            base = a_q.size();
            feed_a(m32, 0, 1'b1, 1'b0);
            wait_n(0, base + 64);
            check_blk(0, base, exp_a, 64);
        end
        a_rand_rdy = 1'b0;
        @(posedge clk); #1;

        // Reset mid-LOAD drops the partial block
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = $urandom;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_a("mid_load_rst");
        for (int i = 0; i < 16; i++) m32[i] = $urandom;
        model32(m32, exp_a);
        base = a_q.size();
        feed_a(m32, 0, 1'b0, 1'b0);
        wait_n(0, base + 64);
        check_blk(0, base, exp_a, 64);

        // Test 4: clear mid-EXPAND, then block B
        for (int i = 0; i < 16; i++) m32[i] = $urandom;
        base = a_q.size();
        feed_a(m32, 0, 1'b0, 1'b0);
        g = 0;
        @(negedge clk);
        while (!(a_w_valid && a_w_index == 7'd19) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) fail_now("t4_wait_t19");
        @(posedge clk); #1;
        a_clear = 1'b1;
        @(posedge clk); #1;
        a_clear = 1'b0;
        qa = a_q.size();
        chk("t4_words_before_clear", 64'(qa - base), 64'd20);
        check_idle_a("t4_after_clear");
        for (int i = 0; i < 16; i++) m32[i] = $urandom;
        model32(m32, exp_a);
        feed_a(m32, 0, 1'b0, 1'b0);
        wait_n(0, qa + 64);
        check_blk(0, qa, exp_a, 64);

        // Test 5: back-to-back blocks, in_valid held high
        for (int i = 0; i < 16; i++) begin
            m32[i]  = $urandom;
            mb32[i] = $urandom;
        end
        model32(m32, exp_a);
        model32(mb32, exp_b);
        base = a_q.size();
        feed_a(m32, 0, 1'b0, 1'b1);
        a_in_data = mb32[0];
        prev_last = 1'b0;
        acc = 1'b0;
        g = 0;
        while (!acc && g < 500) begin
            @(negedge clk);
            if (a_w_valid) begin
                chk("t5_in_ready_expand", 64'(a_in_ready), 64'd0);
            end else if (a_in_ready) begin
                chk("t5_accept_after_last", 64'(prev_last), 64'd1);
                acc = 1'b1;
            end
            prev_last = a_w_valid && a_w_ready && a_w_last;
            @(posedge clk); #1;
            g++;
        end
        if (!acc) fail_now("t5_accept");
        feed_a(mb32, 1, 1'b0, 1'b0);
        wait_n(0, base + 128);
        check_blk(0, base, exp_a, 64);
        check_blk(0, base + 64, exp_b, 64);

        // Test 3: SHA-512 abc block and a random block on B
        model64(abc64, exp_64);
        base2 = b_q.size();
        feed_b(abc64);
        wait_n(1, base2 + 80);
        check_blk(1, base2, exp_64, 80);
        for (int i = 0; i < 16; i++) m64[i] = {$urandom, $urandom};
        model64(m64, exp_b);
        base = b_q.size();
        feed_b(m64);
        wait_n(1, base + 80);
        check_blk(1, base, exp_b, 80);

        // Test 6: byte-swapped input on C reproduces the abc schedule
        for (int i = 0; i < 16; i++) sw32[i] = bswap32(abc32[i]);
        feed_c(sw32);
        wait_n(2, 64);
        check_blk(2, 0, exp_abc, 64);

        // Known-answer table
        for (int i = 0; i < 10; i++) begin
            case (tab[i].which)
                0: base = base1;
                1: base = base2;
                default: base = 0;
            endcase
            if (base + tab[i].idx < qsize(tab[i].which)) begin
                o0 = get_obs(tab[i].which, base + tab[i].idx);
                chk($sformatf("kat[%0d]", i), o0.data, tab[i].w);
            end else begin
                fail_now($sformatf("kat[%0d]_missing", i));
            end
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
